// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types and constants for the ALU reservation station / issue scheduler.
// Lock value of all-ones marks an operand as already holding its data.
package alu_issue_scheduler_pkg;

   localparam int RS_ENTRIES      = 4;
   localparam int ROB_ENTRY_WIDTH = 3;
   localparam int DATA_WIDTH      = 32;
   localparam int OP_WIDTH        = 4;
   localparam int LOCK_WIDTH      = ROB_ENTRY_WIDTH + 1;
   localparam int IDX_W           = $clog2(RS_ENTRIES);
   localparam int CNT_W           = $clog2(RS_ENTRIES + 1);

   localparam logic [LOCK_WIDTH-1:0] NO_LOCK = '1;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
   } simp_op_e;

   typedef struct packed {
      logic                       valid;
      logic [OP_WIDTH-1:0]        op;
      logic [LOCK_WIDTH-1:0]      lock1;
      logic [DATA_WIDTH-1:0]      data1;
      logic [LOCK_WIDTH-1:0]      lock2;
      logic [DATA_WIDTH-1:0]      data2;
      logic [ROB_ENTRY_WIDTH-1:0] dest;
   } rs_entry_t;

   // Out-of-range locks (MSB set, not NO_LOCK) can never equal {0,tag}.
   function automatic rs_entry_t wake(
      input rs_entry_t                  e,
      input logic                       v,
      input logic [ROB_ENTRY_WIDTH-1:0] tag,
      input logic [DATA_WIDTH-1:0]      data
   );
      rs_entry_t r;
      r = e;
      if (v && e.valid) begin
         if (e.lock1 == {1'b0, tag}) begin
            r.lock1 = NO_LOCK;
            r.data1 = data;
         end
         if (e.lock2 == {1'b0, tag}) begin
            r.lock2 = NO_LOCK;
            r.data2 = data;
         end
      end
      return r;
   endfunction

   function automatic logic is_ready(input rs_entry_t e);
      return e.valid && (e.lock1 == NO_LOCK) && (e.lock2 == NO_LOCK);
   endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Decoder, CDB and ALU side signals of the ALU issue scheduler.
// master = environment driving the station, slave = the station itself.
interface alu_issue_scheduler_if;
   import alu_issue_scheduler_pkg::*;

   logic                       flush;
   logic                       dec_write;
   logic [OP_WIDTH-1:0]        dec_op;
   logic [LOCK_WIDTH-1:0]      dec_lock1;
   logic [DATA_WIDTH-1:0]      dec_data1;
   logic [LOCK_WIDTH-1:0]      dec_lock2;
   logic [DATA_WIDTH-1:0]      dec_data2;
   logic [ROB_ENTRY_WIDTH-1:0] dec_dest;
   logic                       alu_stall;
   logic                       cdb_valid;
   logic [ROB_ENTRY_WIDTH-1:0] cdb_tag;
   logic [DATA_WIDTH-1:0]      cdb_data;
   logic                       alu_ready;
   logic                       alu_valid;
   logic [OP_WIDTH-1:0]        alu_op;
   logic [DATA_WIDTH-1:0]      alu_a;
   logic [DATA_WIDTH-1:0]      alu_b;
   logic [ROB_ENTRY_WIDTH-1:0] alu_dest;

   modport master (
      output flush, dec_write, dec_op, dec_lock1, dec_data1,
      output dec_lock2, dec_data2, dec_dest,
      output cdb_valid, cdb_tag, cdb_data, alu_ready,
      input  alu_stall, alu_valid, alu_op, alu_a, alu_b, alu_dest
   );

   modport slave (
      input  flush, dec_write, dec_op, dec_lock1, dec_data1,
      input  dec_lock2, dec_data2, dec_dest,
      input  cdb_valid, cdb_tag, cdb_data, alu_ready,
      output alu_stall, alu_valid, alu_op, alu_a, alu_b, alu_dest
   );

endinterface

// File: rtl/alu_issue_scheduler_entry.sv
// One reservation-station slot: load a new op or shift in its upper
// neighbour, then snoop the CDB on whatever it ends up holding.
module alu_issue_scheduler_entry
   import alu_issue_scheduler_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_i,
   input  logic                       load_i,
   input  logic                       shift_i,
   input  rs_entry_t                  new_i,
   input  rs_entry_t                  nbr_i,
   input  logic                       cdb_valid_i,
   input  logic [ROB_ENTRY_WIDTH-1:0] cdb_tag_i,
   input  logic [DATA_WIDTH-1:0]      cdb_data_i,
   output rs_entry_t                  entry_o,
   output logic                       ready_o
);

   rs_entry_t entry_q;
   rs_entry_t entry_d;
   rs_entry_t src;

   always_comb begin
      src = entry_q;
      if (load_i) begin
         src = new_i;
      end else if (shift_i) begin
         src = nbr_i;
      end
      entry_d = wake(src, cdb_valid_i, cdb_tag_i, cdb_data_i);
      if (clear_i) begin
         entry_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o = entry_q;
   assign ready_o = is_ready(entry_q);

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: collapsing queue (slot 0 oldest), CDB wake-up,
// oldest-ready select and registered single-issue port to the ALU.
module alu_issue_scheduler
   import alu_issue_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   alu_issue_scheduler_if.slave bus
);

   rs_entry_t                  slot_q [RS_ENTRIES];
   rs_entry_t                  nbr    [RS_ENTRIES];
   logic [RS_ENTRIES-1:0]      ready;
   rs_entry_t                  new_e;
   logic [CNT_W-1:0]           count_q;
   logic [CNT_W-1:0]           count_d;
   logic [CNT_W-1:0]           wpos;
   logic [IDX_W-1:0]           sel;
   logic                       any_ready;
   logic                       issue;
   logic                       accept;
   logic                       stall;

   logic                       alu_valid_q;
   logic [OP_WIDTH-1:0]        alu_op_q;
   logic [DATA_WIDTH-1:0]      alu_a_q;
   logic [DATA_WIDTH-1:0]      alu_b_q;
   logic [ROB_ENTRY_WIDTH-1:0] alu_dest_q;

   assign stall  = (count_q == CNT_W'(RS_ENTRIES));
   assign issue  = bus.alu_ready && any_ready && !bus.flush;
   assign accept = bus.dec_write && !stall && !bus.flush;
   assign wpos   = count_q - CNT_W'(issue);

   assign new_e = '{
      valid: 1'b1,
      op:    bus.dec_op,
      lock1: bus.dec_lock1,
      data1: bus.dec_data1,
      lock2: bus.dec_lock2,
      data2: bus.dec_data2,
      dest:  bus.dec_dest
   };

   // Scan from the top so the lowest (oldest) ready slot wins.
   always_comb begin
      sel       = '0;
      any_ready = 1'b0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
         if (ready[i]) begin
            sel       = IDX_W'(i);
            any_ready = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_slot
      if (g < RS_ENTRIES - 1) begin : g_nbr
         assign nbr[g] = slot_q[g+1];
      end else begin : g_top
         assign nbr[g] = '0;
      end

      alu_issue_scheduler_entry u_entry (
         .clk         (clk),
         .rst         (rst),
         .clear_i     (bus.flush),
         .load_i      (accept && (wpos == CNT_W'(g))),
         .shift_i     (issue && (IDX_W'(g) >= sel)),
         .new_i       (new_e),
         .nbr_i       (nbr[g]),
         .cdb_valid_i (bus.cdb_valid),
         .cdb_tag_i   (bus.cdb_tag),
         .cdb_data_i  (bus.cdb_data),
         .entry_o     (slot_q[g]),
         .ready_o     (ready[g])
      );
   end

   always_comb begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
      if (bus.flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         alu_valid_q <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_dest_q  <= '0;
      end else begin
         count_q     <= count_d;
         alu_valid_q <= issue;
         if (issue) begin
            alu_op_q   <= slot_q[sel].op;
            alu_a_q    <= slot_q[sel].data1;
            alu_b_q    <= slot_q[sel].data2;
            alu_dest_q <= slot_q[sel].dest;
         end
      end
   end

   assign bus.alu_stall = stall;
   assign bus.alu_valid = alu_valid_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_dest  = alu_dest_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed testbench for alu_issue_scheduler with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_alu_issue_scheduler;
   import alu_issue_scheduler_pkg::*;

   localparam logic [3:0] NL = 4'hF;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   alu_issue_scheduler_if bus ();

   alu_issue_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] lk(input logic [2:0] tag);
      return {1'b0, tag};
   endfunction

   task automatic idle();
      bus.flush     = 1'b0;
      bus.dec_write = 1'b0;
      bus.dec_op    = '0;
      bus.dec_lock1 = NL;
      bus.dec_data1 = '0;
      bus.dec_lock2 = NL;
      bus.dec_data2 = '0;
      bus.dec_dest  = '0;
      bus.cdb_valid = 1'b0;
      bus.cdb_tag   = '0;
      bus.cdb_data  = '0;
      bus.alu_ready = 1'b0;
   endtask

   task automatic wr(input logic [3:0] op, input logic [3:0] l1,
                     input logic [31:0] d1, input logic [3:0] l2,
                     input logic [31:0] d2, input logic [2:0] dest);
      bus.dec_write = 1'b1;
      bus.dec_op    = op;
      bus.dec_lock1 = l1;
      bus.dec_data1 = d1;
      bus.dec_lock2 = l2;
      bus.dec_data2 = d2;
      bus.dec_dest  = dest;
   endtask

   task automatic cdb(input logic v, input logic [2:0] tag,
                      input logic [31:0] data);
      bus.cdb_valid = v;
      bus.cdb_tag   = tag;
      bus.cdb_data  = data;
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      idle();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", bus.alu_valid, 0);
      chk("rst_stall", bus.alu_stall, 0);
      chk("rst_op", bus.alu_op, 0);
      chk("rst_a", bus.alu_a, 0);
      chk("rst_dest", bus.alu_dest, 0);
      chk("rst_count", dut.count_q, 0);
      rst = 1'b0;

      // ready ADD: issue two edges after the write edge
      bus.alu_ready = 1'b1;
      wr(OP_ADD, NL, 5, NL, 7, 2);
      tick();
      bus.dec_write = 1'b0;
      chk("add_wcyc_valid", bus.alu_valid, 0);
      tick();
      chk("add_valid", bus.alu_valid, 1);
      chk("add_op", bus.alu_op, OP_ADD);
      chk("add_a", bus.alu_a, 5);
      chk("add_b", bus.alu_b, 7);
      chk("add_dest", bus.alu_dest, 2);
      tick();
      chk("add_drain", bus.alu_valid, 0);

      // lock1 on tag 3, woken by CDB the next cycle
      wr(OP_SUB, lk(3), 0, NL, 2, 4);
      tick();
      bus.dec_write = 1'b0;
      cdb(1, 3, 32'h10);
      tick();
      cdb(0, 0, 0);
      chk("wake_wait", bus.alu_valid, 0);
      tick();
      chk("wake_valid", bus.alu_valid, 1);
      chk("wake_a", bus.alu_a, 32'h10);
      chk("wake_b", bus.alu_b, 2);
      chk("wake_dest", bus.alu_dest, 4);
      tick();

      // fill to full, 5th write ignored, also while full+issuing
      bus.alu_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(OP_AND, NL, 32'(i), lk(1), 0, 3'(i));
         tick();
      end
      chk("full_stall", bus.alu_stall, 1);
      chk("full_count", dut.count_q, 4);
      wr(OP_OR, NL, 9, NL, 9, 7);
      tick();
      bus.dec_write = 1'b0;
      chk("full_5th_count", dut.count_q, 4);
      chk("full_5th_valid", bus.alu_valid, 0);
      cdb(1, 1, 32'h55);
      tick();
      cdb(0, 0, 0);
      bus.alu_ready = 1'b1;
      wr(OP_OR, NL, 9, NL, 9, 7);
      tick();
      bus.dec_write = 1'b0;
      chk("drain0_dest", bus.alu_dest, 0);
      chk("drain0_b", bus.alu_b, 32'h55);
      chk("drain0_count", dut.count_q, 3);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("drain_valid", bus.alu_valid, 1);
         chk("drain_dest", bus.alu_dest, 3'(i));
         chk("drain_a", bus.alu_a, 32'(i));
      end
      tick();
      chk("drain_end", bus.alu_valid, 0);
      chk("drain_count", dut.count_q, 0);

      // younger ready op overtakes older waiting op
      bus.alu_ready = 1'b0;
      wr(OP_XOR, lk(6), 0, NL, 1, 5);
      tick();
      wr(OP_ADD, NL, 3, NL, 4, 6);
      tick();
      bus.dec_write = 1'b0;
      bus.alu_ready = 1'b1;
      tick();
      chk("ooo_first_valid", bus.alu_valid, 1);
      chk("ooo_first_dest", bus.alu_dest, 6);
      chk("ooo_count", dut.count_q, 1);
      cdb(1, 6, 32'h99);
      tick();
      cdb(0, 0, 0);
      chk("ooo_gap", bus.alu_valid, 0);
      tick();
      chk("ooo_second_dest", bus.alu_dest, 5);
      chk("ooo_second_a", bus.alu_a, 32'h99);
      tick();

      // CDB broadcast in the write cycle is bypassed into the new op
      wr(OP_SLT, lk(5), 0, NL, 32'h22, 1);
      cdb(1, 5, 32'hAB);
      tick();
      bus.dec_write = 1'b0;
      cdb(0, 0, 0);
      tick();
      chk("byp_valid", bus.alu_valid, 1);
      chk("byp_a", bus.alu_a, 32'hAB);
      chk("byp_b", bus.alu_b, 32'h22);
      chk("byp_dest", bus.alu_dest, 1);
      tick();

      // out-of-range lock never matches the CDB
      wr(OP_SRL, 4'b1010, 0, NL, 0, 3);
      tick();
      bus.dec_write = 1'b0;
      cdb(1, 2, 32'h77);
      tick();
      cdb(0, 0, 0);
      tick();
      chk("oor_valid", bus.alu_valid, 0);
      chk("oor_count", dut.count_q, 1);

      // flush clears everything; later CDB is irrelevant
      bus.alu_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr(OP_SUB, lk(2), 0, NL, 0, 3'(i));
         tick();
      end
      bus.dec_write = 1'b0;
      chk("fl_pre_count", dut.count_q, 3);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl_count", dut.count_q, 0);
      chk("fl_stall", bus.alu_stall, 0);
      chk("fl_valid", bus.alu_valid, 0);
      cdb(1, 2, 32'h5);
      bus.alu_ready = 1'b1;
      tick();
      cdb(0, 0, 0);
      tick();
      chk("fl_after_valid", bus.alu_valid, 0);
      chk("fl_after_count", dut.count_q, 0);

      // flush beats an issue in the same cycle
      wr(OP_ADD, NL, 1, NL, 1, 7);
      tick();
      bus.dec_write = 1'b0;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl_issue_valid", bus.alu_valid, 0);
      chk("fl_issue_count", dut.count_q, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
